// File: rtl/amc_ioctl_streamer.sv
// amc_ioctl_streamer
// Replays a valid/ready byte stream as paced ioctl write strobes for the
// AlphaMission ROM loaders, starting at a programmed base address.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   begin a transfer (sampled only while idle)
//   base_addr, length       first address and byte count, latched on start
//   s_data/s_valid/s_ready  byte source handshake
//   ioctl_addr/data/wr      download address, byte and write strobe
//   ioctl_download          high for the whole transfer
//   busy, done, err         status: not idle, end pulse, sticky range error
//   csum                    16-bit byte sum (only with AMC_IOCTL_CHECKSUM_EN)
//
// Optional feature macro: AMC_IOCTL_CHECKSUM_EN adds the csum output.
module amc_ioctl_streamer #(
   parameter int unsigned WR_PULSE = 1,
   parameter int unsigned WR_GAP   = 4,
   parameter int unsigned ADDR_W   = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_data,
   output logic              ioctl_wr,
   output logic              ioctl_download,
   output logic              busy,
   output logic              done,
`ifdef AMC_IOCTL_CHECKSUM_EN
   output logic [15:0]       csum,
`endif
   output logic              err
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned SUM_W = ADDR_W + 2;
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WR_PULSE - 1);
   // Only meaningful when the gap is enabled.
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(WR_GAP - 1);
   localparam bit               GAP_EN     = (WR_GAP != 0);
   localparam logic [ADDR_W:0]  LEN_ONE    = (ADDR_W+1)'(1);
   localparam logic [SUM_W-1:0] ADDR_SPAN  = SUM_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      STROBE,
      HOLD,
      FINISH
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   phase_cnt;
   logic [ADDR_W:0]    len_q;
   logic [ADDR_W:0]    sent_cnt;

   logic [SUM_W-1:0]   end_addr_c;
   logic               range_bad_c;
   logic [ADDR_W:0]    sent_next_c;
   logic               last_byte_c;
   logic               byte_end_c;

   // Range check: one past the last address must not exceed the address space.
   assign end_addr_c  = SUM_W'(base_addr) + SUM_W'(length);
   assign range_bad_c = (end_addr_c > ADDR_SPAN);

   assign sent_next_c = sent_cnt + LEN_ONE;
   assign last_byte_c = (sent_next_c == len_q);

   // Byte finishes at the end of HOLD, or at the end of STROBE when there is no gap.
   assign byte_end_c = ((state == STROBE) && (phase_cnt == PULSE_LAST) && !GAP_EN) ||
                       ((state == HOLD)   && (phase_cnt == GAP_LAST)   &&  GAP_EN);

   // Sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         phase_cnt      <= '0;
         len_q          <= '0;
         sent_cnt       <= '0;
         s_ready        <= 1'b0;
         ioctl_addr     <= '0;
         ioctl_data     <= '0;
         ioctl_wr       <= 1'b0;
         ioctl_download <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= length;
                  sent_cnt <= '0;
                  err      <= 1'b0;
                  if (length == '0) begin
                     busy  <= 1'b1;
                     done  <= 1'b1;
                     state <= FINISH;
                  end else if (range_bad_c) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     ioctl_addr     <= base_addr;
                     ioctl_download <= 1'b1;
                     s_ready        <= 1'b1;
                     busy           <= 1'b1;
                     state          <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (s_valid && s_ready) begin
                  ioctl_data <= s_data;
                  s_ready    <= 1'b0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               ioctl_wr  <= 1'b1;
               phase_cnt <= '0;
               state     <= STROBE;
            end
            STROBE: begin
               if (phase_cnt == PULSE_LAST) begin
                  ioctl_wr  <= 1'b0;
                  phase_cnt <= '0;
                  if (GAP_EN) begin
                     state <= HOLD;
                  end
               end else begin
                  phase_cnt <= phase_cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               phase_cnt <= phase_cnt + CNT_W'(1);
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // End-of-byte bookkeeping overrides the per-state next state.
         if (byte_end_c) begin
            sent_cnt <= sent_next_c;
            if (last_byte_c) begin
               ioctl_download <= 1'b0;
               done           <= 1'b1;
               state          <= FINISH;
            end else begin
               ioctl_addr <= ioctl_addr + ADDR_W'(1);
               s_ready    <= 1'b1;
               state      <= FETCH;
            end
         end
      end
   end

`ifdef AMC_IOCTL_CHECKSUM_EN
   // Running byte sum, taken once per byte in the first strobe cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum <= '0;
      end else if ((state == IDLE) && start) begin
         csum <= '0;
      end else if ((state == STROBE) && (phase_cnt == '0)) begin
         csum <= csum + 16'(ioctl_data);
      end
   end
`endif

endmodule

// File: tb/tb_amc_ioctl_streamer.sv
// tb_amc_ioctl_streamer
// Directed bench for amc_ioctl_streamer with default parameters
// (WR_PULSE=1, WR_GAP=4, ADDR_W=20). Checksum cases are built only
// when AMC_IOCTL_CHECKSUM_EN is defined.
module tb_amc_ioctl_streamer;

   localparam int unsigned ADDR_W = 20;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_data;
   logic              ioctl_wr;
   logic              ioctl_download;
   logic              busy;
   logic              done;
   logic              err;
`ifdef AMC_IOCTL_CHECKSUM_EN
   logic [15:0]       csum;
`endif

   amc_ioctl_streamer dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .ioctl_addr     (ioctl_addr),
      .ioctl_data     (ioctl_data),
      .ioctl_wr       (ioctl_wr),
      .ioctl_download (ioctl_download),
      .busy           (busy),
      .done           (done),
`ifdef AMC_IOCTL_CHECKSUM_EN
      .csum           (csum),
`endif
      .err            (err)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Source bytes and observations from the last transfer.
   logic [7:0]        src     [16];
   logic [ADDR_W-1:0] wr_addr [16];
   logic [7:0]        wr_data [16];
   int                wr_cyc  [16];
   int                acc_cyc [16];
   int                wr_count;
   int                done_cyc;
   int                max_w;
   bit                dl_seen;
   logic              err_at_done;
   logic              busy_at_done;
   logic              dl_at_done;
   logic [15:0]       csum_at_done;

   // Run one transfer; optional stall before byte stall_idx, start spam while
   // busy, and a reset injected on the rising strobe of write number rst_wr.
   task automatic run_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                           input int stall_idx, input int stall_len,
                           input bit spam, input int rst_wr);
      int idx, cyc, stall_left, run_w;
      bit fire, fin, late_done;
      idx = 0; cyc = 0; stall_left = stall_len; run_w = 0; fin = 0; late_done = 0;
      wr_count = 0; done_cyc = -1; max_w = 0; dl_seen = 0;
      err_at_done = 1'bx; busy_at_done = 1'bx; dl_at_done = 1'bx; csum_at_done = 'x;
      base_addr = b; length = n; start = 1'b1; s_valid = 1'b0; s_data = src[0];
      while (!fin && cyc < 300) begin
         fire = s_ready && s_valid;
         @(posedge clk); #1;
         cyc++;
         start = spam;
         if (spam) base_addr = 20'h12345;
         if (fire) begin
            acc_cyc[idx % 16] = cyc;
            idx++;
         end
         if (ioctl_download) dl_seen = 1;
         if (ioctl_wr) begin
            if (run_w == 0 && wr_count < 16) begin
               wr_addr[wr_count] = ioctl_addr;
               wr_data[wr_count] = ioctl_data;
               wr_cyc[wr_count]  = cyc;
               wr_count++;
            end
            run_w++;
            if (run_w > max_w) max_w = run_w;
         end else begin
            run_w = 0;
         end

         if (rst_wr != 0 && wr_count == rst_wr && ioctl_wr) begin
            reset = 1'b1; start = 1'b0; s_valid = 1'b0;
            @(posedge clk); #1;
            chk("rst_wr",   32'(ioctl_wr),       0);
            chk("rst_dl",   32'(ioctl_download), 0);
            chk("rst_busy", 32'(busy),           0);
            chk("rst_done", 32'(done),           0);
            reset = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               if (done) late_done = 1;
            end
            chk("rst_no_done", 32'(late_done), 0);
            fin = 1;
         end else begin
            if (done) begin
               done_cyc     = cyc;
               err_at_done  = err;
               busy_at_done = busy;
               dl_at_done   = ioctl_download;
`ifdef AMC_IOCTL_CHECKSUM_EN
               csum_at_done = csum;
`endif
               fin   = 1;
               start = 1'b0;
            end
            s_valid = 1'b0;
            if (!fin && idx < int'(n)) begin
               if (idx == stall_idx && stall_left > 0 && (s_ready || stall_left < stall_len)) begin
                  chk("stall_ready", 32'(s_ready),    1);
                  chk("stall_wr",    32'(ioctl_wr),   0);
                  chk("stall_addr",  32'(ioctl_addr), 32'(b) + 32'(stall_idx));
                  stall_left--;
               end else begin
                  s_valid = 1'b1;
               end
            end
            s_data = src[idx % 16];
         end
      end
      if (!fin) chk("timeout", 0, 1);
      start = 1'b0; s_valid = 1'b0;
      // One more cycle so the sequencer is back in IDLE.
      @(posedge clk); #1;
      chk("post_busy", 32'(busy), 0);
      chk("post_done", 32'(done), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      base_addr = '0; length = '0;
      for (int i = 0; i < 16; i++) src[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready",  32'(s_ready),        0);
      chk("rst_addr",     32'(ioctl_addr),     0);
      chk("rst_data",     32'(ioctl_data),     0);
      chk("rst_ioctl_wr", 32'(ioctl_wr),       0);
      chk("rst_download", 32'(ioctl_download), 0);
      chk("rst_busy0",    32'(busy),           0);
      chk("rst_done0",    32'(done),           0);
      chk("rst_err",      32'(err),            0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic 4-byte transfer, source always valid.
      src[0] = 8'hA5; src[1] = 8'h5A; src[2] = 8'hFF; src[3] = 8'h00;
      run_xfer(20'h00000, 21'd4, -1, 0, 1'b0, 0);
      chk("t1_count", 32'(wr_count), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_addr%0d", i), 32'(wr_addr[i]), 32'(i));
         chk($sformatf("t1_data%0d", i), 32'(wr_data[i]), 32'(src[i]));
      end
      for (int i = 1; i < 4; i++)
         chk($sformatf("t1_spacing%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 7);
      chk("t1_width",      32'(max_w), 1);
      chk("t1_latency",    32'(wr_cyc[0] - acc_cyc[0]), 1);
      chk("t1_done_delay", 32'(done_cyc - wr_cyc[3]), 5);
      chk("t1_dl_at_done", 32'(dl_at_done), 0);
      chk("t1_err",        32'(err_at_done), 0);
      chk("t1_hold_addr",  32'(ioctl_addr), 32'h3);
      chk("t1_hold_data",  32'(ioctl_data), 32'h00);

      // Same transfer, 10-cycle stall before the second byte, start spammed while busy.
      run_xfer(20'h00000, 21'd4, 1, 10, 1'b1, 0);
      chk("t2_count", 32'(wr_count), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_addr%0d", i), 32'(wr_addr[i]), 32'(i));
         chk($sformatf("t2_data%0d", i), 32'(wr_data[i]), 32'(src[i]));
      end
      chk("t2_stall_gap", 32'(wr_cyc[1] - wr_cyc[0]), 17);
      chk("t2_spacing",   32'(wr_cyc[2] - wr_cyc[1]), 7);

      // Zero-length transfer.
      run_xfer(20'h00100, 21'd0, -1, 0, 1'b0, 0);
      chk("t3_done_cyc", 32'(done_cyc), 1);
      chk("t3_count",    32'(wr_count), 0);
      chk("t3_dl_seen",  32'(dl_seen), 0);
      chk("t3_busy",     32'(busy_at_done), 1);
      chk("t3_err",      32'(err_at_done), 0);

      // Out-of-range request, then the largest legal one at the top of memory.
      run_xfer(20'hFFFFE, 21'd3, -1, 0, 1'b0, 0);
      chk("t4_done_cyc", 32'(done_cyc), 1);
      chk("t4_err",      32'(err_at_done), 1);
      chk("t4_busy",     32'(busy_at_done), 0);
      chk("t4_count",    32'(wr_count), 0);
      chk("t4_dl_seen",  32'(dl_seen), 0);
      chk("t4_err_sticky", 32'(err), 1);
      src[0] = 8'h11; src[1] = 8'h3C;
      run_xfer(20'hFFFFE, 21'd2, -1, 0, 1'b0, 0);
      chk("t4b_err",   32'(err_at_done), 0);
      chk("t4b_count", 32'(wr_count), 2);
      chk("t4b_addr0", 32'(wr_addr[0]), 32'hFFFFE);
      chk("t4b_addr1", 32'(wr_addr[1]), 32'hFFFFF);
      chk("t4b_data0", 32'(wr_data[0]), 32'h11);
      chk("t4b_data1", 32'(wr_data[1]), 32'h3C);
      chk("t4b_hold_addr", 32'(ioctl_addr), 32'hFFFFF);
      chk("t4b_hold_data", 32'(ioctl_data), 32'h3C);

      // Reset during the strobe of byte 2 of 5, then a 1-byte transfer.
      src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04; src[4] = 8'h05;
      run_xfer(20'h00040, 21'd5, -1, 0, 1'b0, 2);
      chk("t5_count", 32'(wr_count), 2);
      src[0] = 8'h77;
      run_xfer(20'h00080, 21'd1, -1, 0, 1'b0, 0);
      chk("t5b_count", 32'(wr_count), 1);
      chk("t5b_addr",  32'(wr_addr[0]), 32'h80);
      chk("t5b_data",  32'(wr_data[0]), 32'h77);
      chk("t5b_err",   32'(err_at_done), 0);
      chk("t5b_dl",    32'(dl_at_done), 0);

`ifdef AMC_IOCTL_CHECKSUM_EN
      src[0] = 8'h80; src[1] = 8'h80; src[2] = 8'h01;
      run_xfer(20'h00200, 21'd3, -1, 0, 1'b0, 0);
      chk("t6_csum", 32'(csum_at_done), 32'h0101);
      run_xfer(20'h00200, 21'd0, -1, 0, 1'b0, 0);
      chk("t6_csum_clear", 32'(csum_at_done), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
